// File: rtl/sm_operand_collector_if.sv
// Operand collector handshake bundle: instruction in, RF read port, operands out.
// slave = collector side, master = producer/consumer/RF side.
interface sm_operand_collector_if #(
  parameter int NUM_THREADS     = 256,
  parameter int REGS_PER_THREAD = 16,
  parameter int REG_WIDTH       = 32,
  parameter int TAG_W           = 8
);
  localparam int TID_W  = $clog2(NUM_THREADS);
  localparam int RIDX_W = $clog2(REGS_PER_THREAD);
  localparam int ADDR_W = $clog2(NUM_THREADS * REGS_PER_THREAD);

  logic              in_valid;
  logic              in_ready;
  logic [TID_W-1:0]  in_tid;
  logic [RIDX_W-1:0] in_src0;
  logic [RIDX_W-1:0] in_src1;
  logic [RIDX_W-1:0] in_src2;
  logic [1:0]        in_nsrc;
  logic [TAG_W-1:0]  in_tag;

  logic [ADDR_W-1:0]    rf_rd_addr;
  logic                 rf_rd_en;
  logic [REG_WIDTH-1:0] rf_rd_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [TID_W-1:0]     out_tid;
  logic [TAG_W-1:0]     out_tag;
  logic [REG_WIDTH-1:0] out_op0;
  logic [REG_WIDTH-1:0] out_op1;
  logic [REG_WIDTH-1:0] out_op2;

  modport slave (
    input  in_valid, in_tid, in_src0, in_src1,
    input  in_src2, in_nsrc, in_tag,
    output in_ready,
    output rf_rd_addr, rf_rd_en,
    input  rf_rd_data,
    output out_valid, out_tid, out_tag,
    output out_op0, out_op1, out_op2,
    input  out_ready
  );

  modport master (
    output in_valid, in_tid, in_src0, in_src1,
    output in_src2, in_nsrc, in_tag,
    input  in_ready,
    input  rf_rd_addr, rf_rd_en,
    output rf_rd_data,
    input  out_valid, out_tid, out_tag,
    input  out_op0, out_op1, out_op2,
    output out_ready
  );
endinterface

// File: rtl/sm_operand_collector.sv
// Operand collector: one instr in flight, pipelined RF reads, operand bundle out.
// Define ZERO_REG_EN to make source register 0 read as constant zero.
module sm_operand_collector #(
  parameter int NUM_THREADS     = 256,
  parameter int REGS_PER_THREAD = 16,
  parameter int REG_WIDTH       = 32,
  parameter int TAG_W           = 8
) (
  input logic clk,
  input logic rst,
  sm_operand_collector_if.slave bus
);
  localparam int TID_W  = $clog2(NUM_THREADS);
  localparam int RIDX_W = $clog2(REGS_PER_THREAD);
  localparam int ADDR_W = $clog2(NUM_THREADS * REGS_PER_THREAD);

`ifdef ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, HOLD
  } state_t;

  state_t state, state_nx;

  logic [TID_W-1:0]     tid_q;
  logic [RIDX_W-1:0]    src0_q, src1_q, src2_q;
  logic [1:0]           nsrc_q;
  logic [1:0]           cnt_q;
  logic [TAG_W-1:0]     tag_q;
  logic [REG_WIDTH-1:0] op0_q, op1_q, op2_q;

  logic       cap_vld_q;
  logic       cap_zero_q;
  logic [1:0] cap_idx_q;

  logic              accept;
  logic              last_rd;
  logic              out_fire;
  logic [RIDX_W-1:0] cur_src;
  logic [ADDR_W-1:0] rd_addr;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign last_rd  = (cnt_q == nsrc_q - 2'd1);

  always_comb begin
    cur_src = src2_q;
    unique case (1'b1)
      (cnt_q == 2'd0): cur_src = src0_q;
      (cnt_q == 2'd1): cur_src = src1_q;
      default:         cur_src = src2_q;
    endcase
  end

  assign rd_addr = ADDR_W'(tid_q) * ADDR_W'(REGS_PER_THREAD)
                 + ADDR_W'(cur_src);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (bus.in_nsrc == 2'd0) ? HOLD : READ;
      READ:
        if (last_rd) state_nx = DRAIN;
      DRAIN:
        state_nx = HOLD;
      HOLD:
        if (out_fire) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.out_valid  = (state == HOLD);
    bus.rf_rd_en   = (state == READ);
    bus.rf_rd_addr = '0;
    if (state == READ) bus.rf_rd_addr = rd_addr;
  end

  // Capture stage trails the request by one cycle to match the RF read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      tid_q      <= '0;
      src0_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      nsrc_q     <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      op0_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      cap_vld_q  <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_idx_q  <= '0;
    end else begin
      cap_vld_q  <= (state == READ);
      cap_idx_q  <= cnt_q;
      cap_zero_q <= ZERO_EN && (cur_src == '0);

      if (accept) begin
        tid_q  <= bus.in_tid;
        src0_q <= bus.in_src0;
        src1_q <= bus.in_src1;
        src2_q <= bus.in_src2;
        nsrc_q <= bus.in_nsrc;
        tag_q  <= bus.in_tag;
        cnt_q  <= '0;
        op0_q  <= '0;
        op1_q  <= '0;
        op2_q  <= '0;
      end else if (state == READ) begin
        cnt_q <= cnt_q + 2'd1;
      end

      if (cap_vld_q) begin
        unique case (1'b1)
          (cap_idx_q == 2'd0):
            op0_q <= cap_zero_q ? '0 : bus.rf_rd_data;
          (cap_idx_q == 2'd1):
            op1_q <= cap_zero_q ? '0 : bus.rf_rd_data;
          default:
            op2_q <= cap_zero_q ? '0 : bus.rf_rd_data;
        endcase
      end
    end
  end

  assign bus.out_tid = tid_q;
  assign bus.out_tag = tag_q;
  assign bus.out_op0 = op0_q;
  assign bus.out_op1 = op1_q;
  assign bus.out_op2 = op2_q;

endmodule

// File: tb/tb_sm_operand_collector.sv
// Scoreboard bench for sm_operand_collector with a 1-cycle synchronous RF model.
// Expected bundles are queued at issue and checked by a monitor on out handshake.
module tb_sm_operand_collector;
  logic clk;
  logic rst;

  sm_operand_collector_if #(
    .NUM_THREADS(256), .REGS_PER_THREAD(16),
    .REG_WIDTH(32), .TAG_W(8)
  ) bus ();

  sm_operand_collector #(
    .NUM_THREADS(256), .REGS_PER_THREAD(16),
    .REG_WIDTH(32), .TAG_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct {
    logic [7:0]  tid;
    logic [7:0]  tag;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [4096];
  logic [31:0] rf_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.rf_rd_en) rf_q <= mem[bus.rf_rd_addr];
  assign bus.rf_rd_data = rf_q;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_tid", 32'(bus.out_tid), 32'(e.tid));
        chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
        chk("out_op0", bus.out_op0, e.op0);
        chk("out_op1", bus.out_op1, e.op1);
        chk("out_op2", bus.out_op2, e.op2);
      end
    end
  end

  task automatic drive(input logic [7:0] tid, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [1:0] n, input logic [7:0] tag);
    bus.in_valid = 1'b1;
    bus.in_tid   = tid;
    bus.in_src0  = s0;
    bus.in_src1  = s1;
    bus.in_src2  = s2;
    bus.in_nsrc  = n;
    bus.in_tag   = tag;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic accept_wait(input bit push, input exp_t e);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] tid, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [1:0] n, input logic [7:0] tag,
                       input bit push, input exp_t e);
    drive(tid, s0, s1, s2, n, tag);
    accept_wait(push, e);
  endtask

  exp_t e;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[81] = 32'hA;
    mem[82] = 32'hB;
    mem[83] = 32'hC;
    mem[32] = 32'hDEAD;
    rf_q = '0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(8'd0, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);
    bus.in_valid = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.rf_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rf_rd_addr), 32'd0);

    // 2: three sources, pipelined reads
    e = '{tid: 8'd5, tag: 8'h3C, op0: 32'hA, op1: 32'hB, op2: 32'hC};
    issue(8'd5, 4'd1, 4'd2, 4'd3, 2'd3, 8'h3C, 1'b1, e);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_rd_en", 32'(bus.rf_rd_en), 32'd1);
      chk("t2_rd_addr", 32'(bus.rf_rd_addr), 32'(81 + c));
      chk("t2_early_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("t2_drain_rd_en", 32'(bus.rf_rd_en), 32'd0);
    chk("t2_drain_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("t2_drain_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t2_e4_valid", 32'(bus.out_valid), 32'd1);

    // 3: no sources
    @(posedge clk);
    #1;
    e = '{tid: 8'd9, tag: 8'h11, op0: 32'd0, op1: 32'd0, op2: 32'd0};
    issue(8'd9, 4'd7, 4'd8, 4'd9, 2'd0, 8'h11, 1'b1, e);
    @(negedge clk);
    chk("t3_e0_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_rd_en", 32'(bus.rf_rd_en), 32'd0);

    // 4: back-pressure, second instr held off
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    e = '{tid: 8'd7, tag: 8'h44, op0: 32'hC0DE_0074, op1: 32'd0, op2: 32'd0};
    issue(8'd7, 4'd4, 4'd0, 4'd0, 2'd1, 8'h44, 1'b1, e);
    drive(8'd1, 4'd3, 4'd5, 4'd0, 2'd2, 8'h55);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
      if (c >= 2) begin
        chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_hold_op0", bus.out_op0, 32'hC0DE_0074);
        chk("t4_hold_tag", 32'(bus.out_tag), 32'h44);
      end
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t4_after_in_ready", 32'(bus.in_ready), 32'd1);
    e = '{tid: 8'd1, tag: 8'h55, op0: 32'hC0DE_0013,
          op1: 32'hC0DE_0015, op2: 32'd0};
    accept_wait(1'b1, e);
    repeat (4) @(negedge clk);

    // 5: reset mid-READ, then max address
    @(posedge clk);
    #1;
    issue(8'd9, 4'd1, 4'd2, 4'd3, 2'd3, 8'h99, 1'b0, e);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rd_en", 32'(bus.rf_rd_en), 32'd0);
    chk("t5_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
    chk("t5_op0", bus.out_op0, 32'd0);
    chk("t5_tag", 32'(bus.out_tag), 32'd0);
    e = '{tid: 8'd255, tag: 8'h5A, op0: 32'hC0DE_0FFF, op1: 32'd0, op2: 32'd0};
    issue(8'd255, 4'd15, 4'd0, 4'd0, 2'd1, 8'h5A, 1'b1, e);
    @(negedge clk);
    chk("t5_max_addr", 32'(bus.rf_rd_addr), 32'd4095);
    repeat (3) @(negedge clk);

    // 6: source register 0
    @(posedge clk);
    #1;
    e = '{tid: 8'd2, tag: 8'h06, op0: ZR ? 32'd0 : 32'hDEAD,
          op1: 32'd0, op2: 32'd0};
    issue(8'd2, 4'd0, 4'd0, 4'd0, 2'd1, 8'h06, 1'b1, e);
    @(negedge clk);
    chk("t6_rd_addr", 32'(bus.rf_rd_addr), 32'd32);
    repeat (3) @(negedge clk);

    // 7: two sources, one of them register 0
    @(posedge clk);
    #1;
    e = '{tid: 8'd0, tag: 8'h77, op0: 32'hC0DE_000F,
          op1: ZR ? 32'd0 : 32'hC0DE_0000, op2: 32'd0};
    issue(8'd0, 4'd15, 4'd0, 4'd9, 2'd2, 8'h77, 1'b1, e);
    repeat (6) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
